// File: rtl/pid_pkg.sv
// Shared types and default sizing for the PID controller and its actuator stages.
package pid_pkg;

    localparam int D_WIDTH_DEF = 16;
    localparam int LIM_MAX_DEF = 4096;
    localparam int LIM_MIN_DEF = -4096;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } pwm_state_t;

    typedef struct packed {
        logic [D_WIDTH_DEF-1:0] mag;
        logic                   dir;
        logic                   sat;
    } pwm_cmd_t;

endpackage

// File: rtl/pwm_saturate.sv
// Combinational clip of a signed command into [LIM_MIN, LIM_MAX], split into magnitude, direction and clip flag.
module pwm_saturate #(
    parameter int D_WIDTH = pid_pkg::D_WIDTH_DEF,
    parameter int LIM_MAX = pid_pkg::LIM_MAX_DEF,
    parameter int LIM_MIN = pid_pkg::LIM_MIN_DEF
) (
    input  logic signed [D_WIDTH-1:0] i_cmd,
    input  logic                      i_prev_dir,
    output logic        [D_WIDTH-1:0] o_mag,
    output logic                      o_dir,
    output logic                      o_sat
);

    localparam logic signed [D_WIDTH-1:0] CLIP_MAX = D_WIDTH'(LIM_MAX);
    localparam logic signed [D_WIDTH-1:0] CLIP_MIN = D_WIDTH'(LIM_MIN);

    logic signed [D_WIDTH-1:0] w_clip;

    // A zero command carries no direction information, so the previous direction is kept.
    always_comb begin
        w_clip = i_cmd;
        o_sat  = 1'b0;
        if (i_cmd > CLIP_MAX) begin
            w_clip = CLIP_MAX;
            o_sat  = 1'b1;
        end else if (i_cmd < CLIP_MIN) begin
            w_clip = CLIP_MIN;
            o_sat  = 1'b1;
        end
        o_dir = (w_clip == '0) ? i_prev_dir : w_clip[D_WIDTH-1];
        o_mag = w_clip[D_WIDTH-1] ? $unsigned(-w_clip) : $unsigned(w_clip);
    end

endmodule

// File: rtl/pwm_bridge_out.sv
// Saturating edge-aligned PWM driver for an H-bridge; period_start paces the PID iterate_enable.
// Define PWM_DEADTIME_EN to build the DEAD blanking state that follows a direction reversal.
module pwm_bridge_out #(
    parameter int D_WIDTH  = pid_pkg::D_WIDTH_DEF,
    parameter int LIM_MAX  = pid_pkg::LIM_MAX_DEF,
    parameter int LIM_MIN  = pid_pkg::LIM_MIN_DEF,
    parameter int DEADTIME = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic signed [D_WIDTH-1:0] cmd,
    input  logic                      cmd_valid,
    output logic                      in_a,
    output logic                      in_b,
    output logic                      sat,
    output logic                      period_start
);

    import pid_pkg::*;

    localparam int CNT_W = $clog2(LIM_MAX);

    pwm_state_t         r_state;
    logic [CNT_W-1:0]   r_count;
    pwm_cmd_t           r_pend;
    pwm_cmd_t           r_app;
    logic               r_in_a;
    logic               r_in_b;
    logic               r_sat;
    logic               r_period_start;

    logic [D_WIDTH-1:0] w_sat_mag;
    logic               w_sat_dir;
    logic               w_sat_flag;
    pwm_cmd_t           w_pend_nxt;
    logic [D_WIDTH-1:0] w_count_ext;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_boundary;
    logic               w_drive;

    pwm_saturate #(
        .D_WIDTH (D_WIDTH),
        .LIM_MAX (LIM_MAX),
        .LIM_MIN (LIM_MIN)
    ) u_saturate (
        .i_cmd      (cmd),
        .i_prev_dir (r_pend.dir),
        .o_mag      (w_sat_mag),
        .o_dir      (w_sat_dir),
        .o_sat      (w_sat_flag)
    );

    // Shadow value as it will be after this cycle, so a strobe on the boundary cycle is applied at once.
    always_comb begin
        w_pend_nxt = r_pend;
        if (cmd_valid) begin
            w_pend_nxt.mag = w_sat_mag;
            w_pend_nxt.dir = w_sat_dir;
            w_pend_nxt.sat = w_sat_flag;
        end
    end

    assign w_count_ext = D_WIDTH'(r_count);
    assign w_boundary  = (r_count == CNT_W'(LIM_MAX - 1));
    assign w_count_nxt = w_boundary ? '0 : r_count + CNT_W'(1);
    assign w_drive     = (w_count_ext < r_app.mag);

    // Outputs default low each cycle and are only raised by an active RUN period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= OFF;
            r_count        <= '0;
            r_pend         <= '0;
            r_app          <= '0;
            r_in_a         <= 1'b0;
            r_in_b         <= 1'b0;
            r_sat          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_pend         <= w_pend_nxt;
            r_in_a         <= 1'b0;
            r_in_b         <= 1'b0;
            r_sat          <= 1'b0;
            r_period_start <= 1'b0;
            if (!enable) begin
                r_state <= OFF;
                r_count <= '0;
            end else begin
                case (r_state)
                    OFF: begin
                        r_state        <= RUN;
                        r_count        <= '0;
                        r_app          <= w_pend_nxt;
                        r_sat          <= w_pend_nxt.sat;
                        r_period_start <= 1'b1;
                    end
                    RUN: begin
                        r_in_a  <= w_drive & ~r_app.dir;
                        r_in_b  <= w_drive & r_app.dir;
                        r_sat   <= r_app.sat;
                        r_count <= w_count_nxt;
                        if (w_boundary) begin
                            r_app          <= w_pend_nxt;
                            r_sat          <= w_pend_nxt.sat;
                            r_period_start <= 1'b1;
`ifdef PWM_DEADTIME_EN
                            if ((w_pend_nxt.dir != r_app.dir) && (w_pend_nxt.mag != '0))
                                r_state <= DEAD;
`endif
                        end
                    end
`ifdef PWM_DEADTIME_EN
                    // Blanking shares the period counter, so it shortens the first period after reversal.
                    DEAD: begin
                        r_sat   <= r_app.sat;
                        r_count <= w_count_nxt;
                        if ((w_count_ext + D_WIDTH'(1)) >= D_WIDTH'(DEADTIME))
                            r_state <= RUN;
                    end
`endif
                    default: begin
                        r_state <= OFF;
                        r_count <= '0;
                        r_pend  <= '0;
                        r_app   <= '0;
                    end
                endcase
            end
        end
    end

    assign in_a         = r_in_a;
    assign in_b         = r_in_b;
    assign sat          = r_sat;
    assign period_start = r_period_start;

endmodule
